mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single main-memory/LSU refill port between the instruction cache and the data cache.
- Sits between the i_cache/d_cache memory-request interfaces and the lsu memory-request/response interface.
- Grants one cache at a time and latches that cache's line request. It routes the memory response back to the granted cache only, using round-robin priority on ties.
- Exports per-requester grant counters for performance monitoring.

Parameters:
- ADDR_W, 32, memory address width.
- LINE_W, 128, cache line width (width of the refill/writeback data).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- ic_req_valid_i  in  1  i-cache requests a line read; held high until ic_ready_o seen.
- ic_req_addr_i  in  ADDR_W  i-cache line address.
- ic_data_o  out  LINE_W  line data returned to i-cache.
- ic_ready_o  out  1  one-cycle completion strobe to i-cache.
- dc_req_valid_i  in  1  d-cache request (refill or writeback); held until dc_ready_o.
- dc_req_rw_i  in  1  1 = write line, 0 = read line.
- dc_req_addr_i  in  ADDR_W  d-cache line address.
- dc_req_data_i  in  LINE_W  writeback line data.
- dc_data_o  out  LINE_W  line data returned to d-cache.
- dc_ready_o  out  1  one-cycle completion strobe to d-cache.
- mem_req_valid_o  out  1  request to memory.
- mem_req_rw_o  out  1  memory write enable.
- mem_req_addr_o  out  ADDR_W  memory address.
- mem_req_data_o  out  LINE_W  memory write data.
- mem_data_i  in  LINE_W  memory read data.
- mem_ready_i  in  1  memory completion strobe.
- busy_o  out  1  a grant is active.
- ic_grants_o  out  32  count of completed i-cache transactions.
- dc_grants_o  out  32  count of completed d-cache transactions.

Behaviour:
- Reset: async on rst_ni low.
  - FSM goes to IDLE; last_served = IC.
  - All latched request registers are cleared.
  - All outputs are 0 during and after reset; both counters are 0.
- FSM states: IDLE, GNT_IC, GNT_DC.
- IDLE transitions:
  - Only ic valid → GNT_IC.
  - Only dc valid → GNT_DC.
  - Both valid → grant the requester that is not last_served. After reset the first tie goes to DC.
  - Neither valid → stay in IDLE.
- Grant latching:
  - On the IDLE→GNT_x edge, the granted requester's addr/rw/data are latched into the request registers.
  - For IC, rw is forced to 0 and data to 0.
  - The requester may change its inputs afterwards; they are ignored until the next grant.
- Memory-side outputs while in GNT_x:
  - mem_req_valid_o = 1.
  - mem_req_addr_o, mem_req_rw_o and mem_req_data_o are driven from the latched registers.
  - In IDLE all mem_req_* outputs are 0.
  - First mem_req_valid_o comes one cycle after the request is seen in IDLE.
- Response in GNT_x with mem_ready_i = 1:
  - x_ready_o = 1 and x_data_o = mem_data_i in the same cycle (combinational).
  - The other requester's ready is 0 and its data is 0.
  - Next edge: FSM → IDLE, last_served = x, x_grants_o increments.
- Back-to-back requests: the requester drops valid in the cycle after its ready. IDLE re-arbitrates in that cycle, so there is one idle memory cycle between transactions.
- Ignored inputs:
  - mem_ready_i in IDLE has no effect and produces no ready strobe.
  - A request arriving while the other requester is granted waits; it is never dropped.
- busy_o = 1 in GNT_IC and GNT_DC, 0 in IDLE.
- Counters: 32-bit, saturate at 0xFFFFFFFF with no wrap. They are cleared only by rst_ni.
- Reset mid-transaction: the grant is abandoned with no ready strobe and no counter update. The requester must re-issue.
- No starvation: with both caches requesting continuously, grants strictly alternate.

Test Plan:
1. Reset, then ic valid with addr 0x0000_0100; mem_ready_i pulses 3 cycles after mem_req_valid_o with data 0xA5…A5 → mem_req_addr_o=0x100 and rw=0; ic_ready_o pulses one cycle with data 0xA5…A5; ic_grants_o=1; dc_ready_o stays 0.
2. Both valid in the same cycle right after reset → DC granted first. After DC completes and drops valid, IC is granted. Continuous requests from both give the order DC, IC, DC, IC.
3. dc write of addr 0x200 with data 0x1234…: change dc_req_data_i after the grant → memory sees the latched 0x1234… with rw=1 until mem_ready_i.
4. Pulse mem_ready_i while in IDLE → no ready strobes, counters unchanged, busy_o=0.
5. Deassert rst_ni during GNT_IC before mem_ready_i → all outputs 0 immediately, FSM IDLE, ic_grants_o=0; reissuing the request completes normally.
6. Force dc_grants_o to 0xFFFFFFFF, then complete one more DC transaction → the counter stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory refill port between i-cache and d-cache
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ic_req_valid_i,
    input  logic [ADDR_W-1:0] ic_req_addr_i,
    output logic [LINE_W-1:0] ic_data_o,
    output logic              ic_ready_o,
    input  logic              dc_req_valid_i,
    input  logic              dc_req_rw_i,
    input  logic [ADDR_W-1:0] dc_req_addr_i,
    input  logic [LINE_W-1:0] dc_req_data_i,
    output logic [LINE_W-1:0] dc_data_o,
    output logic              dc_ready_o,
    output logic              mem_req_valid_o,
    output logic              mem_req_rw_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [LINE_W-1:0] mem_req_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic [31:0]       ic_grants_o,
    output logic [31:0]       dc_grants_o
);
    typedef enum logic [1:0] {IDLE, GNT_IC, GNT_DC} state_e;

    state_e            state_q, state_d;
    logic              last_dc_q, last_dc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic [31:0]       ic_grants_q, ic_grants_d;
    logic [31:0]       dc_grants_q, dc_grants_d;
    logic              pick_dc;
    logic              grant;
    logic              ic_done;
    logic              dc_done;

    // State register; an asynchronous reset abandons any grant in flight without a strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_dc_q   <= 1'b0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            data_q      <= '0;
            ic_grants_q <= '0;
            dc_grants_q <= '0;
        end else begin
            state_q     <= state_d;
            last_dc_q   <= last_dc_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            data_q      <= data_d;
            ic_grants_q <= ic_grants_d;
            dc_grants_q <= dc_grants_d;
        end
    end

    // Next state: on a tie the cache that was not served last wins, so the first tie goes to DC
    always_comb begin
        pick_dc = dc_req_valid_i && (!ic_req_valid_i || !last_dc_q);
        state_d = state_q;
        case (state_q)
            IDLE:           state_d = (ic_req_valid_i || dc_req_valid_i) ? (pick_dc ? GNT_DC : GNT_IC) : IDLE;
            GNT_IC, GNT_DC: state_d = mem_ready_i ? IDLE : state_q;
            default:        state_d = IDLE;
        endcase
    end

    // Request capture on the grant edge, round-robin history and saturating grant counters
    always_comb begin
        grant       = (state_q == IDLE) && (ic_req_valid_i || dc_req_valid_i);
        addr_d      = grant ? (pick_dc ? dc_req_addr_i : ic_req_addr_i) : addr_q;
        rw_d        = grant ? (pick_dc && dc_req_rw_i) : rw_q;
        data_d      = grant ? (pick_dc ? dc_req_data_i : '0) : data_q;
        last_dc_d   = ic_done ? 1'b0 : (dc_done ? 1'b1 : last_dc_q);
        ic_grants_d = (ic_done && ic_grants_q != '1) ? ic_grants_q + 32'd1 : ic_grants_q;
        dc_grants_d = (dc_done && dc_grants_q != '1) ? dc_grants_q + 32'd1 : dc_grants_q;
    end

    // Outputs: memory side is driven only while granted, responses route only to the granted cache
    always_comb begin
        busy_o          = state_q != IDLE;
        ic_done         = (state_q == GNT_IC) && mem_ready_i;
        dc_done         = (state_q == GNT_DC) && mem_ready_i;
        ic_ready_o      = ic_done;
        dc_ready_o      = dc_done;
        ic_data_o       = ic_done ? mem_data_i : '0;
        dc_data_o       = dc_done ? mem_data_i : '0;
        mem_req_valid_o = busy_o;
        mem_req_rw_o    = busy_o && rw_q;
        mem_req_addr_o  = busy_o ? addr_q : '0;
        mem_req_data_o  = busy_o ? data_q : '0;
        ic_grants_o     = ic_grants_q;
        dc_grants_o     = dc_grants_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a latency-programmable memory responder
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req_valid_i = 1'b0;
    logic [AW-1:0] ic_req_addr_i = '0;
    logic [LW-1:0] ic_data_o;
    logic          ic_ready_o;
    logic          dc_req_valid_i = 1'b0;
    logic          dc_req_rw_i = 1'b0;
    logic [AW-1:0] dc_req_addr_i = '0;
    logic [LW-1:0] dc_req_data_i = '0;
    logic [LW-1:0] dc_data_o;
    logic          dc_ready_o;
    logic          mem_req_valid_o;
    logic          mem_req_rw_o;
    logic [AW-1:0] mem_req_addr_o;
    logic [LW-1:0] mem_req_data_o;
    logic [LW-1:0] mem_data_i = '0;
    logic          mem_ready_i = 1'b0;
    logic          busy_o;
    logic [31:0]   ic_grants_o;
    logic [31:0]   dc_grants_o;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
        .ic_data_o(ic_data_o), .ic_ready_o(ic_ready_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_rw_i(dc_req_rw_i),
        .dc_req_addr_i(dc_req_addr_i), .dc_req_data_i(dc_req_data_i),
        .dc_data_o(dc_data_o), .dc_ready_o(dc_ready_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_rw_o(mem_req_rw_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
        .mem_data_i(mem_data_i), .mem_ready_i(mem_ready_i),
        .busy_o(busy_o), .ic_grants_o(ic_grants_o), .dc_grants_o(dc_grants_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t ic_exp[$];
    txn_t dc_exp[$];
    bit   order_exp[$];
    txn_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   resp_lat = 3;
    int   wait_cnt = 0;
    bit   idle_pulse = 1'b0;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {16{8'hA5}} ^ {96'd0, a ^ 32'h100};
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // memory responder: answers resp_lat cycles after seeing a request, driven just after posedge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ready_i = 1'b0;
            mem_data_i  = '0;
            if (idle_pulse) begin
                mem_ready_i = 1'b1;
                mem_data_i  = '1;
                idle_pulse  = 1'b0;
            end else if (mem_req_valid_o) begin
                if (wait_cnt >= resp_lat) begin
                    mem_ready_i = 1'b1;
                    mem_data_i  = line_of(mem_req_addr_o);
                    wait_cnt    = 0;
                end else wait_cnt++;
            end else wait_cnt = 0;
        end
    end

    // scoreboard: pop the expected transaction whenever a completion strobe appears
    always @(negedge clk) begin
        if (ic_ready_o) begin
            check("ic_other_ready", dc_ready_o, 0);
            check("ic_other_data", dc_data_o, 0);
            check("ic_pending", ic_exp.size() != 0, 1);
            if (ic_exp.size() != 0) begin
                mon_e = ic_exp.pop_front();
                check("ic_mem_addr", mem_req_addr_o, mon_e.addr);
                check("ic_mem_rw", mem_req_rw_o, 0);
                check("ic_mem_wdata", mem_req_data_o, 0);
                check("ic_data", ic_data_o, line_of(mon_e.addr));
            end
            if (order_exp.size() != 0) check("order", 0, order_exp.pop_front());
        end
        if (dc_ready_o) begin
            check("dc_other_ready", ic_ready_o, 0);
            check("dc_other_data", ic_data_o, 0);
            check("dc_pending", dc_exp.size() != 0, 1);
            if (dc_exp.size() != 0) begin
                mon_e = dc_exp.pop_front();
                check("dc_mem_addr", mem_req_addr_o, mon_e.addr);
                check("dc_mem_rw", mem_req_rw_o, mon_e.rw);
                check("dc_mem_wdata", mem_req_data_o, mon_e.wdata);
                check("dc_data", dc_data_o, line_of(mon_e.addr));
            end
            if (order_exp.size() != 0) check("order", 1, order_exp.pop_front());
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_mem_valid", mem_req_valid_o, 0);
        check("rst_ic_grants", ic_grants_o, 0);
        check("rst_dc_grants", dc_grants_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic ic_txn(input logic [AW-1:0] a);
        int i;
        @(negedge clk);
        ic_req_valid_i = 1'b1;
        ic_req_addr_i  = a;
        ic_exp.push_back('{rw: 1'b0, addr: a, wdata: '0});
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!ic_ready_o && i < 60);
        check("ic_ready_seen", ic_ready_o, 1);
        ic_req_valid_i = 1'b0;
        ic_req_addr_i  = '0;
    endtask

    task automatic dc_txn(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] d, input bit scramble);
        int i;
        @(negedge clk);
        dc_req_valid_i = 1'b1;
        dc_req_rw_i    = rw;
        dc_req_addr_i  = a;
        dc_req_data_i  = d;
        dc_exp.push_back('{rw: rw, addr: a, wdata: d});
        i = 0;
        do begin
            @(negedge clk);
            i++;
            if (scramble && mem_req_valid_o) begin
                dc_req_data_i = ~d;
                dc_req_addr_i = a ^ 32'hFF0;
                dc_req_rw_i   = ~rw;
            end
        end while (!dc_ready_o && i < 60);
        check("dc_ready_seen", dc_ready_o, 1);
        dc_req_valid_i = 1'b0;
        dc_req_rw_i    = 1'b0;
        dc_req_data_i  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        // single i-cache read
        ic_txn(32'h0000_0100);
        @(negedge clk);
        check("t1_ic_grants", ic_grants_o, 1);
        check("t1_dc_grants", dc_grants_o, 0);
        check("t1_idle_busy", busy_o, 0);
        check("t1_idle_addr", mem_req_addr_o, 0);
        // tie after reset goes to DC, then strict alternation
        do_reset();
        order_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
        fork
            begin
                ic_txn(32'h0000_0140);
                ic_txn(32'h0000_0180);
            end
            begin
                dc_txn(1'b0, 32'h0000_0240, '0, 1'b0);
                dc_txn(1'b0, 32'h0000_0280, '0, 1'b0);
            end
        join
        @(negedge clk);
        check("t2_order_drained", order_exp.size(), 0);
        check("t2_ic_grants", ic_grants_o, 2);
        check("t2_dc_grants", dc_grants_o, 2);
        // write with inputs changed after the grant
        dc_txn(1'b1, 32'h0000_0200, {4{32'h1234_5678}}, 1'b1);
        @(negedge clk);
        check("t3_dc_grants", dc_grants_o, 3);
        // memory strobe while idle is ignored
        idle_pulse = 1'b1;
        @(negedge clk);
        check("t4_pulse_seen", mem_ready_i, 1);
        check("t4_ic_ready", ic_ready_o, 0);
        check("t4_dc_ready", dc_ready_o, 0);
        check("t4_busy", busy_o, 0);
        @(negedge clk);
        check("t4_ic_grants", ic_grants_o, 2);
        check("t4_dc_grants", dc_grants_o, 3);
        check("t4_still_idle", busy_o, 0);
        // reset in the middle of an i-cache grant
        resp_lat = 20;
        ic_req_valid_i = 1'b1;
        ic_req_addr_i  = 32'h0000_0340;
        repeat (2) @(negedge clk);
        check("t5_busy", busy_o, 1);
        check("t5_mem_addr", mem_req_addr_o, 32'h340);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_valid", mem_req_valid_o, 0);
        check("t5_rst_addr", mem_req_addr_o, 0);
        check("t5_rst_ready", ic_ready_o, 0);
        check("t5_rst_ic_grants", ic_grants_o, 0);
        ic_req_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        resp_lat = 3;
        ic_txn(32'h0000_0340);
        @(negedge clk);
        check("t5_reissue_grants", ic_grants_o, 1);
        // saturation of the d-cache counter
        force dut.dc_grants_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.dc_grants_q;
        @(negedge clk);
        check("t6_preset", dc_grants_o, 32'hFFFF_FFFF);
        dc_txn(1'b0, 32'h0000_0600, '0, 1'b0);
        @(negedge clk);
        check("t6_saturated", dc_grants_o, 32'hFFFF_FFFF);
        check("t6_ic_grants", ic_grants_o, 1);
        check("end_ic_queue", ic_exp.size(), 0);
        check("end_dc_queue", dc_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
